// File: rtl/sliding_window_delay.sv
`default_nettype none
// ============================================================================
// sliding_window_delay : run-time programmable circular-buffer delay line
// Revision: 1.0
// ============================================================================
module sliding_window_delay #(
  parameter int DATA_LENGTH = 16,
  parameter int W_MAX       = 512,
  parameter int AW          = $clog2(W_MAX)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AW:0]            len,
  input  logic                   len_load,
  input  logic                   in_valid,
  input  logic [DATA_LENGTH-1:0] in,
  output logic [DATA_LENGTH-1:0] out,
  output logic                   out_valid,
  output logic                   full,
  output logic [AW:0]            count
);

  localparam logic [AW:0] c_wmax = (AW+1)'(W_MAX);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [AW:0]            r_len_q;
  logic [AW:0]            w_len_nxt;
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          w_ptr_nxt;
  logic [AW:0]            r_count;
  logic [AW:0]            w_count_nxt;
  logic [AW:0]            w_count_inc;
  logic                   w_wrap;
  logic                   w_accept;
  logic [DATA_LENGTH-1:0] r_mem [W_MAX];

  assign w_count_inc = r_count + 1'b1;
  assign w_wrap      = ({1'b0, r_wr_ptr} == (r_len_q - 1'b1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= FILL;
      r_len_q  <= c_wmax;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_len_q  <= w_len_nxt;
      r_wr_ptr <= w_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // len_load flushes and wins over a coincident sample, which is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len_q;
    w_ptr_nxt   = r_wr_ptr;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    if (len_load) begin
      w_len_nxt   = ((len == '0) || (len > c_wmax)) ? c_wmax : len;
      w_ptr_nxt   = '0;
      w_count_nxt = '0;
      w_state_nxt = FILL;
    end else if (in_valid) begin
      w_accept  = 1'b1;
      w_ptr_nxt = w_wrap ? '0 : r_wr_ptr + 1'b1;
      if (r_state == FILL) begin
        w_count_nxt = w_count_inc;
        if (w_count_inc >= r_len_q) begin
          w_state_nxt = RUN;
        end
      end
    end
  end

  // Memory is deliberately left unreset; FILL masks stale contents to zero.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= in;
    end
  end

  // Read-before-write on the same slot returns the evicted sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_accept;
      if (w_accept) begin
        out <= (r_state == RUN) ? r_mem[r_wr_ptr] : '0;
      end
    end
  end

  assign full  = (r_state == RUN);
  assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sliding_window_delay.sv
`default_nettype none
// Directed self-checking bench for sliding_window_delay.
module tb_sliding_window_delay;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  len = '0;
  logic        len_load = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in = '0;
  logic [15:0] out;
  logic        out_valid;
  logic        full;
  logic [9:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  sliding_window_delay dut (
    .clk       (clk),
    .reset     (reset),
    .len       (len),
    .len_load  (len_load),
    .in_valid  (in_valid),
    .in        (in),
    .out       (out),
    .out_valid (out_valid),
    .full      (full),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d);
    @(negedge clk);
    in_valid = v;
    in       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] l);
    @(negedge clk);
    len_load = 1'b1;
    len      = l;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    len_load = 1'b0;
  endtask

  // Stream values 1..n; expected eviction is j-L once j exceeds L.
  task automatic stream(input bit do_load, input int lval, input int L, input int n);
    logic [15:0] last;
    if (do_load) load(lval[9:0]);
    last = '0;
    for (int j = 1; j <= n; j++) begin
      step(1'b1, j[15:0]);
      last = (j > L) ? 16'(j - L) : 16'd0;
      check("strm_out", out, last);
      check("strm_vld", out_valid, 1);
      check("strm_cnt", count, (j < L) ? j : L);
      check("strm_full", full, (j >= L) ? 1 : 0);
    end
    step(1'b0, 16'hdead);
    check("idle_vld", out_valid, 0);
    check("idle_out", out, last);
  endtask

  logic [15:0] exp2 [6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd10, 16'd20};
  logic [15:0] exp3 [3] = '{16'd0, 16'd5, 16'd6};
  logic [15:0] exp5 [4] = '{16'd0, 16'd0, 16'd0, 16'd100};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 0);
    check("rst_vld", out_valid, 0);
    check("rst_full", full, 0);
    check("rst_cnt", count, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: len=300, continuous stream of 700
    stream(1'b1, 300, 300, 700);

    // 2: len=4, alternate-cycle input, wrap 3->0
    load(10'd4);
    check("s2_cnt0", count, 0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 16'(10 * (k + 1)));
      check("s2_out", out, exp2[k]);
      check("s2_vld", out_valid, 1);
      step(1'b0, 16'hbeef);
      check("s2_gap_vld", out_valid, 0);
      check("s2_gap_out", out, exp2[k]);
    end
    check("s2_full", full, 1);

    // 3: len=1, read-before-write on one slot
    load(10'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'(5 + k));
      check("s3_out", out, exp3[k]);
      check("s3_full", full, 1);
    end
    step(1'b0, 16'h0);

    // 4: out-of-range lengths clamp to 512
    stream(1'b1, 0, 512, 520);
    stream(1'b1, 517, 512, 1025);

    // 5: len_load colliding with in_valid drops the sample
    stream(1'b1, 8, 8, 20);
    @(negedge clk);
    len_load = 1'b1;
    len      = 10'd3;
    in_valid = 1'b1;
    in       = 16'd999;
    @(posedge clk);
    #1;
    len_load = 1'b0;
    in_valid = 1'b0;
    check("s5_vld", out_valid, 0);
    check("s5_cnt", count, 0);
    check("s5_full", full, 0);
    check("s5_out_hold", out, 12);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 16'(100 + k));
      check("s5_out", out, exp5[k]);
    end
    step(1'b0, 16'h0);

    // 6: asynchronous reset between edges
    load(10'd5);
    for (int j = 1; j <= 8; j++) step(1'b1, j[15:0]);
    check("s6_pre_out", out, 3);
    check("s6_pre_vld", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("s6_rst_out", out, 0);
    check("s6_rst_vld", out_valid, 0);
    check("s6_rst_cnt", count, 0);
    check("s6_rst_full", full, 0);
    @(negedge clk);
    reset = 1'b0;
    stream(1'b0, 0, 512, 520);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
